// File: rtl/uart_tx_module.sv
// UART serialiser in the baud-clock domain: one clock = one bit period.
// Frame: start, data LSB first, optional parity, 1 or 2 stop bits.
//
// Ports:
//   i_clk           baud-rate clock
//   i_rst           synchronous active-high reset
//   i_user_tx_data  word to send, sampled on handshake
//   i_user_tx_valid upstream has a word
//   o_user_tx_ready block accepts a word this cycle (registered)
//   o_uart_tx       serial line, idle high (registered)
module uart_tx_module #(
    parameter int p_DATA_WIDTH  = 8,
    parameter int p_PARITY_TYPE = 0,
    parameter int p_STOP_WIDTH  = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [p_DATA_WIDTH-1:0] i_user_tx_data,
    input  logic                    i_user_tx_valid,
    output logic                    o_user_tx_ready,
    output logic                    o_uart_tx
);

    localparam int CW = $clog2(p_DATA_WIDTH);
    localparam logic [CW-1:0] DATA_LAST = CW'(p_DATA_WIDTH - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(p_STOP_WIDTH - 1);
    localparam bit HAS_PAR = (p_PARITY_TYPE != 0);
    localparam bit ODD_PAR = (p_PARITY_TYPE == 1);
    localparam bit ONE_STOP = (p_STOP_WIDTH == 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [p_DATA_WIDTH-1:0] shift_q, shift_d;
    logic                    par_q, par_d;
    logic                    tx_q, tx_d;
    logic                    rdy_q, rdy_d;
    logic                    hs;
    logic                    par_new;

    assign hs      = i_user_tx_valid && rdy_q;
    assign par_new = (^i_user_tx_data) ^ ODD_PAR;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            rdy_q   <= rdy_d;
        end
    end

    // Outputs are registered, so each branch computes the line value
    // for the state being entered, not the current one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        rdy_d   = rdy_q;
        unique case (state_q)
            IDLE: begin
                tx_d  = 1'b1;
                rdy_d = 1'b1;
                if (hs) begin
                    state_d = START;
                    cnt_d   = '0;
                    shift_d = i_user_tx_data;
                    par_d   = par_new;
                    tx_d    = 1'b0;
                    rdy_d   = 1'b0;
                end
            end
            START: begin
                state_d = DATA;
                cnt_d   = '0;
                tx_d    = shift_q[0];
                shift_d = shift_q >> 1;
            end
            DATA: begin
                if (cnt_q == DATA_LAST) begin
                    cnt_d = '0;
                    if (HAS_PAR) begin
                        state_d = PARITY;
                        tx_d    = par_q;
                    end else begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                        rdy_d   = ONE_STOP;
                    end
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                end
            end
            PARITY: begin
                state_d = STOP;
                cnt_d   = '0;
                tx_d    = 1'b1;
                rdy_d   = ONE_STOP;
            end
            STOP: begin
                if (cnt_q == STOP_LAST) begin
                    cnt_d = '0;
                    if (hs) begin
                        // Back-to-back: next start bit follows with no gap.
                        state_d = START;
                        shift_d = i_user_tx_data;
                        par_d   = par_new;
                        tx_d    = 1'b0;
                        rdy_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                        rdy_d   = 1'b1;
                    end
                end else begin
                    // Entering the final stop cycle: open the handshake.
                    cnt_d = cnt_q + CW'(1);
                    tx_d  = 1'b1;
                    rdy_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                tx_d    = 1'b1;
                rdy_d   = 1'b0;
            end
        endcase
    end

    assign o_uart_tx       = tx_q;
    assign o_user_tx_ready = rdy_q;

endmodule

// File: tb/tb_uart_tx_module.sv
// Directed bench for uart_tx_module: defaults, even parity,
// odd parity with two stop bits, back-to-back, ignored valid, reset.
module tb_uart_tx_module;

    logic       clk;
    logic       rst;
    logic [7:0] data;
    logic [2:0] vld;
    logic [2:0] tx;
    logic [2:0] rdy;
    int         n_chk;
    int         n_err;

    uart_tx_module u_dut0 (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_user_tx_data  (data),
        .i_user_tx_valid (vld[0]),
        .o_user_tx_ready (rdy[0]),
        .o_uart_tx       (tx[0])
    );

    uart_tx_module #(
        .p_DATA_WIDTH  (8),
        .p_PARITY_TYPE (2),
        .p_STOP_WIDTH  (1)
    ) u_dut1 (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_user_tx_data  (data),
        .i_user_tx_valid (vld[1]),
        .o_user_tx_ready (rdy[1]),
        .o_uart_tx       (tx[1])
    );

    uart_tx_module #(
        .p_DATA_WIDTH  (8),
        .p_PARITY_TYPE (1),
        .p_STOP_WIDTH  (2)
    ) u_dut2 (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_user_tx_data  (data),
        .i_user_tx_valid (vld[2]),
        .o_user_tx_ready (rdy[2]),
        .o_uart_tx       (tx[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_rdy(input int k);
        for (int i = 0; i < 50; i++) begin
            if (rdy[k]) break;
            tick();
        end
        check($sformatf("rdy_wait%0d", k), 32'(rdy[k]), 32'd1);
    endtask

    // exp is written in time order: exp[0] is the start bit.
    task automatic send_frame(input int k, input logic [7:0] d,
                              input logic [0:11] exp, input int len,
                              input bit poke);
        wait_rdy(k);
        data   = d;
        vld[k] = 1'b1;
        tick();
        vld[k] = 1'b0;
        for (int i = 0; i < len; i++) begin
            if (i > 0) tick();
            check($sformatf("line%0d_%0d", k, i), 32'(tx[k]), 32'(exp[i]));
            check($sformatf("rdy%0d_%0d", k, i), 32'(rdy[k]),
                  32'(i == len - 1));
            if (poke && i == 4) begin
                data   = 8'hFF;
                vld[k] = 1'b1;
            end
            if (poke && i == 5) vld[k] = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("idle%0d_%0d", k, i), 32'(tx[k]), 32'd1);
            check($sformatf("idlerdy%0d_%0d", k, i), 32'(rdy[k]), 32'd1);
        end
    endtask

    logic [21:0] line;
    int          hs_cyc [2];
    int          hs_n;
    logic        hs_now;

    initial begin
        n_chk = 0;
        n_err = 0;
        rst   = 1'b1;
        vld   = '0;
        data  = '0;

        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_tx", 32'(tx), 32'h7);
            check("rst_rdy", 32'(rdy), 32'h0);
        end
        rst = 1'b0;
        check("rel1_rdy", 32'(rdy), 32'h0);
        check("rel1_tx", 32'(tx), 32'h7);
        tick();
        check("rel2_rdy", 32'(rdy), 32'h7);
        check("rel2_tx", 32'(tx), 32'h7);

        send_frame(0, 8'hA5, 12'b010100101100, 10, 1'b0);
        send_frame(1, 8'hA5, 12'b010100101010, 11, 1'b0);
        send_frame(2, 8'hA5, 12'b010100101111, 12, 1'b0);

        // Back-to-back: valid held, data swapped on each handshake.
        wait_rdy(0);
        data   = 8'h01;
        vld[0] = 1'b1;
        hs_n   = 0;
        line   = '0;
        for (int c = 0; c < 22; c++) begin
            hs_now = vld[0] && rdy[0];
            tick();
            if (hs_now && hs_n < 2) begin
                hs_cyc[hs_n] = c;
                hs_n++;
                if (hs_n == 1) data = 8'h80;
                else vld[0] = 1'b0;
            end
            line[21-c] = tx[0];
        end
        vld[0] = 1'b0;
        check("b2b_hs_n", 32'(hs_n), 32'd2);
        check("b2b_gap", 32'(hs_cyc[1] - hs_cyc[0]), 32'd10);
        check("b2b_line", 32'(line), 32'(22'b0100000001000000001111));

        // Valid pulsed with 0xFF mid-frame must be ignored.
        send_frame(0, 8'h33, 12'b011001100100, 10, 1'b1);

        // Reset during data bit 3 of a 0x00 frame.
        wait_rdy(0);
        data   = 8'h00;
        vld[0] = 1'b1;
        tick();
        vld[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            check($sformatf("zero_%0d", i), 32'(tx[0]), 32'd0);
        end
        rst = 1'b1;
        tick();
        check("mid_rst_tx", 32'(tx), 32'h7);
        check("mid_rst_rdy", 32'(rdy), 32'h0);
        rst = 1'b0;
        check("mid_rel1_rdy", 32'(rdy), 32'h0);
        tick();
        check("mid_rel2_rdy", 32'(rdy), 32'h7);
        check("mid_rel2_tx", 32'(tx), 32'h7);
        send_frame(0, 8'h3C, 12'b000111100100, 10, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_module.md
Name: uart_tx_module

Overview:
- UART serialiser running entirely in the divided baud-clock domain: one i_clk cycle = one bit period.
- Consumes the synchronous reset produced by the rst_gen_module for that domain on i_rst.
- Accepts parallel words over a valid/ready handshake and drives the serial line.
- Frame format: start bit, data LSB first, optional parity, then 1 or 2 stop bits.

Parameters:
- p_DATA_WIDTH, 8: data bits per frame; legal range 5..8.
- p_PARITY_TYPE, 0: 0 = none, 1 = odd, 2 = even.
- p_STOP_WIDTH, 1: number of stop bits; legal values 1 or 2.

Ports:
- i_clk  input  1: baud-rate clock, divided domain.
- i_rst  input  1: reset, synchronous, active-high, from rst_gen_module.
- i_user_tx_data  input  p_DATA_WIDTH: word to send; sampled only on handshake.
- i_user_tx_valid  input  1: upstream has a word.
- o_user_tx_ready  output  1: block can accept a word this cycle.
- o_uart_tx  output  1: serial line, idle high.

Behaviour:
- Clocking and outputs:
  - One clock; all outputs are registered.
  - i_rst is synchronous and active-high.
  - While i_rst = 1: o_uart_tx = 1, o_user_tx_ready = 0, state = IDLE, bit counter = 0, data/parity registers = 0.
- Frame length: F = 1 + p_DATA_WIDTH + P + p_STOP_WIDTH, where P = 0 if p_PARITY_TYPE = 0, else 1.
- Ready after reset: first edge with i_rst = 0 in IDLE sets o_user_tx_ready = 1. Ready is therefore high from the 2nd cycle after reset release.
- Handshake:
  - Transfer occurs at a rising edge where i_user_tx_valid && o_user_tx_ready.
  - i_user_tx_data is latched into the shift register and o_user_tx_ready drops to 0 on that edge.
  - i_user_tx_valid while ready = 0 is ignored; no queueing, no data loss check.
- State machine: IDLE -> START -> DATA -> (PARITY if P = 1) -> STOP -> IDLE or START.
  - IDLE: o_uart_tx = 1. Handshake moves to START.
  - START: o_uart_tx = 0 for exactly 1 cycle. This starts on the cycle immediately after the handshake edge (latency 1).
  - DATA: p_DATA_WIDTH cycles, bit 0 first. The shift register shifts right once per cycle. The counter runs 0..p_DATA_WIDTH-1.
  - PARITY: 1 cycle.
    - Even: XOR of the data bits.
    - Odd: inverted XOR of the data bits.
    - Parity is computed from the latched word, not from the live input.
  - STOP: o_uart_tx = 1 for p_STOP_WIDTH cycles.
    - o_user_tx_ready is asserted for the last stop-bit cycle. The ready register is set at the edge entering that cycle.
    - Handshake during the last stop cycle: next state START. Back-to-back frames have period exactly F and no idle gap.
    - No handshake: IDLE. Ready stays 1.
- Reset mid-frame: the frame is aborted at the reset edge. Line returns high on that edge; there is no partial stop bit. The latched word is discarded.
- Counter: width clog2(p_DATA_WIDTH). It resets to 0 on every state change and never wraps inside DATA.

Test Plan:
- Reset: hold i_rst for 3 cycles, then release. Required: o_uart_tx = 1 throughout; ready = 0 during reset and in the first cycle after release; ready = 1 from the 2nd cycle.
- Single frame, defaults, data 0xA5, one-cycle valid pulse while ready = 1. Required: starting the cycle after the handshake, o_uart_tx = 0,1,0,1,0,0,1,0,1,1. Then ready = 1 during the final (stop) bit, and the line stays idle 1 afterwards.
- Parity, data 0xA5 (4 ones):
  - p_PARITY_TYPE = 2: parity bit 0.
  - p_PARITY_TYPE = 1, p_STOP_WIDTH = 2: parity bit 1, followed by 2 high cycles.
  - Frame lengths: 11 and 12 cycles respectively.
- Back-to-back: hold valid = 1 with data 0x01 then 0x80, swapping data on each handshake. Required: two frames, the second start bit directly after the first stop bit, handshakes exactly 10 cycles apart. Lines: 0,1,0,0,0,0,0,0,0,1 then 0,0,0,0,0,0,0,0,1,1.
- Ignored valid: change data to 0xFF and pulse valid while ready = 0 mid-frame. Required: the current frame is unchanged and no extra frame is sent.
- Reset mid-frame: assert i_rst during the 4th data bit of a 0x00 frame. Required: o_uart_tx = 1 from the reset edge and ready = 0. After release, ready returns in the 2nd cycle and a new 0x3C frame transmits correctly.
